// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared constants, FSM state and payload bundle for the core's pipeline stages
package riscv_pipe_pkg;
    localparam int XLEN_DEF = 32;
    localparam int CTRL_W_DEF = 32;
    localparam int ALU_W_DEF = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_IDX_W = 5;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} pipe_state_t;
    typedef struct packed {
        logic [XLEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] npc;
        logic [CTRL_W_DEF-1:0] cntrl;
        logic [ALU_W_DEF-1:0] alu_ctrl;
        logic [XLEN_DEF-1:0] imm;
        logic [XLEN_DEF-1:0] op_a;
        logic [XLEN_DEF-1:0] op_b;
    } payload_t;
endpackage

// File: rtl/pipe_entry_bypass.sv
// pipe_entry_bypass: one payload register with valid bit, load mux and writeback operand bypass
module pipe_entry_bypass
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CTRL_W = 32,
    parameter int ALU_W = 4,
    parameter bit BYPASS_EN = 1'b1,
    parameter int PW = 6 * XLEN + CTRL_W + ALU_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 ld,
    input  logic                 sel_alt,
    input  logic                 vld_nxt,
    input  logic [PW-1:0]        in_pl,
    input  logic [PW-1:0]        alt_pl,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 valid,
    output logic [PW-1:0]        pl
);
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [CTRL_W-1:0] cntrl;
        logic [ALU_W-1:0] alu_ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
    } pl_t;

    pl_t q, base, nxt;
    logic hit;

    assign pl = q;

    // bypass applies to whatever lands in the register this cycle, captured or held
    always_comb begin
        base = ld ? (sel_alt ? pl_t'(alt_pl) : pl_t'(in_pl)) : q;
        hit = BYPASS_EN && wb_we && wb_rd != '0;
        nxt = base;
        if (hit && base.instr[RS1_LSB +: REG_IDX_W] == wb_rd) nxt.op_a = wb_data;
        if (hit && base.instr[RS2_LSB +: REG_IDX_W] == wb_rd) nxt.op_b = wb_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q <= '0;
            q.instr <= XLEN'(NOP_INSTR);
        end else if (flush) begin
            valid <= 1'b0;
            q <= '0;
            q.instr <= XLEN'(NOP_INSTR);
        end else begin
            valid <= vld_nxt;
            if (ld || valid) q <= nxt;
        end
    end
endmodule

// File: rtl/decode_ex_pipe.sv
// decode_ex_pipe: decode-to-execute stage with 2-entry skid buffer, flush, operand bypass
// and a saturating backpressure counter
module decode_ex_pipe
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CTRL_W = 32,
    parameter int ALU_W = 4,
    parameter int CNT_W = 16,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_instr,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_npc,
    input  logic [CTRL_W-1:0]    in_cntrl,
    input  logic [ALU_W-1:0]     in_alu_ctrl,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_operand_a,
    input  logic [XLEN-1:0]      in_operand_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_instr,
    output logic [XLEN-1:0]      out_pc,
    output logic [XLEN-1:0]      out_npc,
    output logic [CTRL_W-1:0]    out_cntrl,
    output logic [ALU_W-1:0]     out_alu_ctrl,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_operand_a,
    output logic [XLEN-1:0]      out_operand_b,
    input  logic                 flush,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic [CNT_W-1:0]     stall_cnt
);
    localparam int PW = 6 * XLEN + CTRL_W + ALU_W;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic [CTRL_W-1:0] cntrl;
        logic [ALU_W-1:0] alu_ctrl;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
    } pl_t;

    pipe_state_t state, state_nxt;
    pl_t in_pl, main_pl, skid_pl;
    logic accept, drain, skid_v, ld_main, ld_skid;

    assign in_pl = '{instr: in_instr, pc: in_pc, npc: in_npc, cntrl: in_cntrl,
                     alu_ctrl: in_alu_ctrl, imm: in_imm, op_a: in_operand_a, op_b: in_operand_b};
    assign accept = in_valid && in_ready;
    assign drain = out_valid && out_ready;
    assign in_ready = !skid_v;

    always_comb begin
        state_nxt = state == EMPTY ? (accept ? ONE : EMPTY) :
                    state == ONE   ? (accept && !drain ? FULL : (!accept && drain ? EMPTY : ONE)) :
                                     (drain ? ONE : FULL);
    end

    assign ld_main = state == FULL ? drain : accept && (state == EMPTY || drain);
    assign ld_skid = state == ONE && accept && !drain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            stall_cnt <= '0;
        end else begin
            state <= flush ? EMPTY : state_nxt;
            if (out_valid && !out_ready && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    pipe_entry_bypass #(.XLEN(XLEN), .CTRL_W(CTRL_W), .ALU_W(ALU_W), .BYPASS_EN(BYPASS_EN)) u_main (
        .clk(clk), .rst(rst), .flush(flush), .ld(ld_main), .sel_alt(state == FULL),
        .vld_nxt(state_nxt != EMPTY), .in_pl(in_pl), .alt_pl(skid_pl),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .valid(out_valid), .pl(main_pl)
    );

    pipe_entry_bypass #(.XLEN(XLEN), .CTRL_W(CTRL_W), .ALU_W(ALU_W), .BYPASS_EN(BYPASS_EN)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .ld(ld_skid), .sel_alt(1'b0),
        .vld_nxt(state_nxt == FULL), .in_pl(in_pl), .alt_pl({PW{1'b0}}),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .valid(skid_v), .pl(skid_pl)
    );

    assign out_instr = main_pl.instr;
    assign out_pc = main_pl.pc;
    assign out_npc = main_pl.npc;
    assign out_cntrl = main_pl.cntrl;
    assign out_alu_ctrl = main_pl.alu_ctrl;
    assign out_imm = main_pl.imm;
    assign out_operand_a = main_pl.op_a;
    assign out_operand_b = main_pl.op_b;
endmodule
